// File: rtl/apb_bridge_pkg.sv
// Shared types for the core-port to APB3 bridge.
// State encoding and the response data used on errors.
package apb_bridge_pkg;

  typedef enum logic [1:0] {
    IDLE,
    SETUP,
    ACCESS,
    RESP
  } bridge_state_e;

  localparam logic [63:0] ERR_RDATA = '0;

endpackage

// File: rtl/apb_timeout_cnt.sv
// Counts ACCESS wait states and flags when the slave has stalled too long.
// last marks the enabled cycle whose increment reaches TIMEOUT.
module apb_timeout_cnt #(
  parameter int TIMEOUT = 256
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  input  logic en,
  output logic expired,
  output logic last
);

  if (TIMEOUT == 0) begin : g_off
    assign expired = 1'b0;
    assign last    = 1'b0;
  end else begin : g_on
    localparam int W = $clog2(TIMEOUT + 1);

    logic [W-1:0] cnt_q;

    always_ff @(posedge clk) begin
      if (rst || clr) begin
        cnt_q <= '0;
      end else if (en && !expired) begin
        cnt_q <= cnt_q + W'(1);
      end
    end

    assign expired = (cnt_q == W'(TIMEOUT));
    assign last    = en && (cnt_q == W'(TIMEOUT - 1));
  end

endmodule

// File: rtl/mem_apb_bridge.sv
// Single-outstanding bridge from the req/gnt/rvalid core port to APB3.
// Partial writes are refused locally since APB3 carries no strobes.
module mem_apb_bridge
  import apb_bridge_pkg::*;
#(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32,
  parameter int TIMEOUT    = 256
) (
  input  logic                    clk_i,
  input  logic                    rst_i,
  input  logic                    req_i,
  output logic                    gnt_o,
  input  logic [ADDR_WIDTH-1:0]   addr_i,
  input  logic                    we_i,
  input  logic [DATA_WIDTH/8-1:0] be_i,
  input  logic [DATA_WIDTH-1:0]   wdata_i,
  output logic                    rvalid_o,
  output logic [DATA_WIDTH-1:0]   rdata_o,
  output logic                    err_o,
  output logic [ADDR_WIDTH-1:0]   paddr_o,
  output logic                    pwrite_o,
  output logic                    psel_o,
  output logic                    penable_o,
  output logic [DATA_WIDTH-1:0]   pwdata_o,
  input  logic [DATA_WIDTH-1:0]   prdata_i,
  input  logic                    pready_i,
  input  logic                    pslverr_i
);

  localparam int BW = DATA_WIDTH / 8;

  bridge_state_e state_q, state_d;

  logic partial;
  logic done;
  logic cnt_clr;
  logic cnt_en;
  logic expired;
  logic last;

  assign partial = we_i && (be_i != {BW{1'b1}});
  // After expiry the bus is already released, so a late pready is ignored.
  assign done    = pready_i && !expired;
  assign gnt_o   = req_i && (state_q == IDLE);
  assign cnt_clr = (state_q == SETUP);
  assign cnt_en  = (state_q == ACCESS) && !pready_i && !expired;

  apb_timeout_cnt #(
    .TIMEOUT(TIMEOUT)
  ) u_cnt (
    .clk    (clk_i),
    .rst    (rst_i),
    .clr    (cnt_clr),
    .en     (cnt_en),
    .expired(expired),
    .last   (last)
  );

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: begin
        if (req_i) begin
          state_d = partial ? RESP : SETUP;
        end
      end
      SETUP:  state_d = ACCESS;
      ACCESS: begin
        if (done || expired) begin
          state_d = RESP;
        end
      end
      RESP:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rvalid_o  <= 1'b0;
      rdata_o   <= '0;
      err_o     <= 1'b0;
      paddr_o   <= '0;
      pwrite_o  <= 1'b0;
      psel_o    <= 1'b0;
      penable_o <= 1'b0;
      pwdata_o  <= '0;
    end else begin
      rvalid_o <= 1'b0;
      unique case (state_q)
        IDLE: begin
          if (req_i) begin
            paddr_o  <= addr_i;
            pwrite_o <= we_i;
            pwdata_o <= wdata_i;
            if (partial) begin
              rvalid_o <= 1'b1;
              err_o    <= 1'b1;
              rdata_o  <= DATA_WIDTH'(ERR_RDATA);
            end else begin
              psel_o <= 1'b1;
            end
          end
        end
        SETUP: penable_o <= 1'b1;
        ACCESS: begin
          if (done) begin
            psel_o    <= 1'b0;
            penable_o <= 1'b0;
            rvalid_o  <= 1'b1;
            err_o     <= pslverr_i;
            rdata_o   <= pwrite_o ? '0 : prdata_i;
          end else if (expired) begin
            rvalid_o <= 1'b1;
            err_o    <= 1'b1;
            rdata_o  <= DATA_WIDTH'(ERR_RDATA);
          end else if (last) begin
            // Release the bus one cycle ahead of the error response.
            psel_o    <= 1'b0;
            penable_o <= 1'b0;
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_mem_apb_bridge.sv
// Self-checking bench for mem_apb_bridge with a short timeout window.
// Table vectors, hand sequences and a randomized run against a model.
module tb_mem_apb_bridge;

  localparam int TO = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req;
  logic        gnt;
  logic [31:0] addr;
  logic        we;
  logic [3:0]  be;
  logic [31:0] wdata;
  logic        rvalid;
  logic [31:0] rdata;
  logic        err;
  logic [31:0] paddr;
  logic        pwrite;
  logic        psel;
  logic        penable;
  logic [31:0] pwdata;
  logic [31:0] prdata;
  logic        pready;
  logic        pslverr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  mem_apb_bridge #(
    .ADDR_WIDTH(32),
    .DATA_WIDTH(32),
    .TIMEOUT   (TO)
  ) dut (
    .clk_i    (clk),
    .rst_i    (rst),
    .req_i    (req),
    .gnt_o    (gnt),
    .addr_i   (addr),
    .we_i     (we),
    .be_i     (be),
    .wdata_i  (wdata),
    .rvalid_o (rvalid),
    .rdata_o  (rdata),
    .err_o    (err),
    .paddr_o  (paddr),
    .pwrite_o (pwrite),
    .psel_o   (psel),
    .penable_o(penable),
    .pwdata_o (pwdata),
    .prdata_i (prdata),
    .pready_i (pready),
    .pslverr_i(pslverr)
  );

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [3:0]  be;
    logic [31:0] wdata;
    logic [31:0] prdata;
    logic        slverr;
    int          waits;
    int          lat;
    logic        err;
    logic [31:0] rdata;
  } vec_t;

  task automatic chk(input string name, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference: latency counts from the grant cycle to the rvalid cycle.
  function automatic void model(input vec_t v, output int lat,
                                output logic e, output logic [31:0] rd);
    if (v.we && v.be != 4'hF) begin
      lat = 1; e = 1'b1; rd = '0;
    end else if (v.waits >= TO) begin
      lat = 3 + TO; e = 1'b1; rd = '0;
    end else begin
      lat = 3 + v.waits;
      e   = v.slverr;
      rd  = v.we ? 32'h0 : v.prdata;
    end
  endfunction

  // Issues one request and plays the APB slave; pready is raised
  // waits cycles into ACCESS whether or not the bridge still selects.
  task automatic run(input vec_t v, output int lat, output logic e,
                     output logic [31:0] rd, output int bad);
    bit partial;
    int pend;
    partial = v.we && (v.be != 4'hF);
    pend = partial ? 0 : ((v.waits >= TO) ? 1 + TO : 2 + v.waits);
    lat = -1; e = 1'b0; rd = '0; bad = 0;
    @(negedge clk);
    req = 1'b1; addr = v.addr; we = v.we; be = v.be; wdata = v.wdata;
    pready = 1'b0;
    #1;
    if (gnt !== 1'b1) bad++;
    for (int k = 1; k <= 40 && lat < 0; k++) begin
      @(negedge clk);
      req = 1'b0;
      addr = $urandom; wdata = $urandom;
      we = 1'($urandom); be = 4'($urandom);
      if (psel !== (k <= pend)) bad++;
      if (penable !== (k >= 2 && k <= pend)) bad++;
      if (psel === 1'b1) begin
        if (paddr !== v.addr || pwrite !== v.we) bad++;
        if (v.we && pwdata !== v.wdata) bad++;
      end
      if (rvalid === 1'b1) begin
        lat = k; e = err; rd = rdata;
      end
      pready  = (k == 2 + v.waits);
      prdata  = pready ? v.prdata : $urandom;
      pslverr = pready ? v.slverr : 1'($urandom);
    end
    @(negedge clk);
    pready = 1'b0;
    if (rvalid !== 1'b0) bad++;
    if (psel !== 1'b0) bad++;
  endtask

  task automatic run_chk(input string tag, input vec_t v,
                         input int xl, input logic xe,
                         input logic [31:0] xr);
    int l;
    int bad;
    logic e;
    logic [31:0] r;
    run(v, l, e, r, bad);
    chk({tag, "_lat"}, 32'(l), 32'(xl));
    chk({tag, "_err"}, {31'b0, e}, {31'b0, xe});
    chk({tag, "_rdata"}, r, xr);
    chk({tag, "_proto"}, 32'(bad), 32'd0);
  endtask

  vec_t tbl[$];
  vec_t v;
  int   ml;
  logic me;
  logic [31:0] mr;

  initial begin
    rst = 1'b1; req = 1'b0; addr = '0; we = 1'b0; be = '0;
    wdata = '0; prdata = '0; pready = 1'b0; pslverr = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_ctrl", {27'b0, rvalid, err, psel, penable, pwrite}, 32'd0);
    chk("rst_rdata", rdata, 32'd0);
    chk("rst_paddr", paddr, 32'd0);
    chk("rst_pwdata", pwdata, 32'd0);
    rst = 1'b0;

    tbl.push_back('{32'h1A10_0004, 1'b0, 4'hF, 32'h0, 32'hCAFE_F00D,
                    1'b0, 0, 3, 1'b0, 32'hCAFE_F00D});
    tbl.push_back('{32'h1A10_2000, 1'b1, 4'hF, 32'h1234_5678,
                    32'h9999_9999, 1'b0, 3, 6, 1'b0, 32'h0});
    tbl.push_back('{32'h1A10_3000, 1'b1, 4'h3, 32'h1111_2222,
                    32'h0, 1'b0, 0, 1, 1'b1, 32'h0});
    tbl.push_back('{32'h1A10_4000, 1'b0, 4'hF, 32'h0, 32'h7777_7777,
                    1'b0, 4, 7, 1'b1, 32'h0});
    tbl.push_back('{32'h1A10_5000, 1'b0, 4'hF, 32'h0, 32'hDEAD_BEEF,
                    1'b1, 3, 6, 1'b1, 32'hDEAD_BEEF});
    tbl.push_back('{32'h1A10_5004, 1'b0, 4'hF, 32'h0, 32'h0000_55AA,
                    1'b0, 3, 6, 1'b0, 32'h0000_55AA});
    tbl.push_back('{32'h1A10_6000, 1'b1, 4'hF, 32'hFEED_0001,
                    32'h0, 1'b0, 10, 7, 1'b1, 32'h0});
    tbl.push_back('{32'h1A10_7000, 1'b1, 4'h0, 32'h0, 32'h0,
                    1'b0, 0, 1, 1'b1, 32'h0});
    tbl.push_back('{32'h1A10_8000, 1'b0, 4'hF, 32'h0, 32'h0BAD_0BAD,
                    1'b1, 0, 3, 1'b1, 32'h0BAD_0BAD});

    foreach (tbl[i]) begin
      run_chk($sformatf("tbl%0d", i), tbl[i], tbl[i].lat, tbl[i].err,
              tbl[i].rdata);
    end

    // Partial write refused, back-to-back request with req held high.
    @(negedge clk);
    req = 1'b1; we = 1'b1; be = 4'h3; addr = 32'h1A10_9000;
    #1 chk("pw_gnt", {31'b0, gnt}, 32'd1);
    @(negedge clk);
    be = 4'h0;
    chk("pw_resp", {28'b0, rvalid, err, psel, gnt}, 32'b1100);
    @(negedge clk);
    chk("pw_regrant", {31'b0, gnt}, 32'd1);
    @(negedge clk);
    req = 1'b0;
    chk("pw2_resp", {29'b0, rvalid, err, psel}, 32'b110);
    @(negedge clk);
    chk("pw2_quiet", {31'b0, rvalid}, 32'd0);

    // Reset during ACCESS drops the write with no response.
    v = tbl[0];
    run_chk("pre_rst", v, 3, 1'b0, 32'hCAFE_F00D);
    @(negedge clk);
    req = 1'b1; we = 1'b1; be = 4'hF;
    addr = 32'h1A10_0008; wdata = 32'hA5A5_A5A5;
    #1 chk("mid_gnt", {31'b0, gnt}, 32'd1);
    @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    chk("mid_access", {30'b0, psel, penable}, 32'b11);
    rst = 1'b1;
    @(negedge clk);
    chk("mid_rst_ctrl", {27'b0, rvalid, err, psel, penable, pwrite}, 32'd0);
    chk("mid_rst_rdata", rdata, 32'd0);
    chk("mid_rst_paddr", paddr, 32'd0);
    chk("mid_rst_pwdata", pwdata, 32'd0);
    rst = 1'b0; req = 1'b1; we = 1'b1; be = 4'h0;
    #1 chk("post_rst_gnt", {31'b0, gnt}, 32'd1);
    @(negedge clk);
    req = 1'b0;
    chk("post_rst_resp", {30'b0, rvalid, err}, 32'b11);
    @(negedge clk);
    chk("post_rst_quiet", {30'b0, rvalid, psel}, 32'd0);

    for (int n = 0; n < 40; n++) begin
      v.addr   = $urandom;
      v.we     = 1'($urandom);
      v.be     = ($urandom_range(0, 3) == 0) ? 4'($urandom) : 4'hF;
      v.wdata  = $urandom;
      v.prdata = $urandom;
      v.slverr = ($urandom_range(0, 3) == 0);
      v.waits  = $urandom_range(0, 6);
      model(v, ml, me, mr);
      run_chk($sformatf("rnd%0d", n), v, ml, me, mr);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
